// File: rtl/cpu_sm_pkg.sv
// Shared types and constants for the CPU state machine bus-termination logic.
// Holds the termination FSM states, PORT_SIZE encodings and the default bus timeout.
package cpu_sm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2,
    ERR  = 2'd3
  } bus_state_e;

  localparam logic [1:0] PS_NONE = 2'b00;
  localparam logic [1:0] PS_BYTE = 2'b01;
  localparam logic [1:0] PS_WORD = 2'b10;
  localparam logic [1:0] PS_LONG = 2'b11;

  localparam int TIMEOUT_CYCLES_DFLT = 255;

  // Argument is the active-low pair {DSACK1_, DSACK0_}.
  function automatic logic [1:0] decode_port_size(input logic [1:0] dsack_n);
    case (dsack_n)
      2'b10:   return PS_BYTE;
      2'b01:   return PS_WORD;
      2'b00:   return PS_LONG;
      default: return PS_NONE;
    endcase
  endfunction

endpackage

// File: rtl/cpu_sync.sv
// N-stage synchroniser for one asynchronous input, reset to a chosen inactive level.
// Latency: STAGES clocks from the first sampling edge to q_o.
module cpu_sync #(
  parameter int   STAGES   = 2,
  parameter logic INACTIVE = 1'b1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= {STAGES{INACTIVE}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cpu_bus_term.sv
// Qualifies raw 68030 termination inputs (DSACK pair, STERM_, BERR_) for the CPU state machine.
// DSACK/BERR reach the outputs SYNC_STAGES+1 clocks after sampling, STERM 1 clock; a bus timeout raises BERR_.
module cpu_bus_term
  import cpu_sm_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DFLT
) (
  input  logic       SCLK,
  input  logic       _RST,
  input  logic       CYCLE_START,
  input  logic       CYCLE_END,
  input  logic       DSACK0_,
  input  logic       DSACK1_,
  input  logic       STERM_IN_,
  input  logic       BERR_IN_,
  output logic       DSACK,
  output logic       STERM_,
  output logic [1:0] PORT_SIZE,
  output logic       BERR_,
  output logic       TIMEOUT
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic dsack0_s;
  logic dsack1_s;
  logic berr_s;

  cpu_sync #(.STAGES(SYNC_STAGES), .INACTIVE(1'b1)) u_sync_dsack0 (
    .clk_i(SCLK), .rst_n_i(_RST), .d_i(DSACK0_), .q_o(dsack0_s)
  );
  cpu_sync #(.STAGES(SYNC_STAGES), .INACTIVE(1'b1)) u_sync_dsack1 (
    .clk_i(SCLK), .rst_n_i(_RST), .d_i(DSACK1_), .q_o(dsack1_s)
  );
  cpu_sync #(.STAGES(SYNC_STAGES), .INACTIVE(1'b1)) u_sync_berr (
    .clk_i(SCLK), .rst_n_i(_RST), .d_i(BERR_IN_), .q_o(berr_s)
  );

  logic [1:0] pair_s;
  logic [1:0] pair_q;
  logic       sterm_q;
  logic       berr_q;
  logic       ds_qual;

  assign pair_s = {dsack1_s, dsack0_s};

  // pair_q is the previous synchronised pair; berr_q gives BERR the same extra clock.
  always_ff @(posedge SCLK or negedge _RST) begin
    if (!_RST) begin
      pair_q  <= 2'b11;
      sterm_q <= 1'b1;
      berr_q  <= 1'b1;
    end else begin
      pair_q  <= pair_s;
      sterm_q <= STERM_IN_;
      berr_q  <= berr_s;
    end
  end

  // Two matching samples reject the transient byte/word code seen while the lines skew.
  assign ds_qual = (pair_s != 2'b11) && (pair_s == pair_q);

  bus_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] ps_q, ps_d;
  logic       by_sterm_q, by_sterm_d;
  logic       timeout_q, timeout_d;

  always_ff @(posedge SCLK or negedge _RST) begin
    if (!_RST) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      ps_q       <= PS_NONE;
      by_sterm_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ps_q       <= ps_d;
      by_sterm_q <= by_sterm_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ps_d       = ps_q;
    by_sterm_d = by_sterm_q;
    timeout_d  = timeout_q;
    if (CYCLE_END) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (CYCLE_START) begin
            state_d   = WAIT;
            cnt_d     = 8'd0;
            timeout_d = 1'b0;
          end
        end
        WAIT: begin
          if (!berr_q) begin
            state_d = ERR;
          end else if (!sterm_q) begin
            state_d    = ACK;
            ps_d       = PS_LONG;
            by_sterm_d = 1'b1;
          end else if (ds_qual) begin
            state_d    = ACK;
            ps_d       = decode_port_size(pair_s);
            by_sterm_d = 1'b0;
          end else if (cnt_q == TO_LAST) begin
            state_d   = ERR;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign DSACK     = (state_q == ACK) && !by_sterm_q;
  assign STERM_    = !((state_q == ACK) && by_sterm_q);
  assign PORT_SIZE = (state_q == ACK) ? ps_q : PS_NONE;
  assign BERR_     = (state_q != ERR);
  assign TIMEOUT   = timeout_q;

endmodule

// File: tb/tb_cpu_bus_term.sv
// Bench for cpu_bus_term: directed bus cycles, literal checkpoints, and a per-cycle
// latency-rule model of the termination outputs.
module tb_cpu_bus_term;

  localparam int S = 2;
  localparam int T = 8;

  logic       clk;
  logic       rst_n = 1'b1;
  logic       cs, ce, ds0, ds1, st, be;
  logic       dsack, sterm_n, berr_n, tmo;
  logic [1:0] ps;

  int checks = 0;
  int errors = 0;

  cpu_bus_term #(.SYNC_STAGES(S), .TIMEOUT_CYCLES(T)) dut (
    .SCLK(clk), ._RST(rst_n), .CYCLE_START(cs), .CYCLE_END(ce),
    .DSACK0_(ds0), .DSACK1_(ds1), .STERM_IN_(st), .BERR_IN_(be),
    .DSACK(dsack), .STERM_(sterm_n), .PORT_SIZE(ps), .BERR_(berr_n), .TIMEOUT(tmo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: outputs follow from the raw samples by the stated latencies.
  // Edge n sees the DSACK pair sampled at n-S and n-S-1, STERM at n-1, BERR at n-S-1.
  int         m_edge = 0;
  int         m_enter = 0;
  int         m_st = 0;  // 0 idle, 1 waiting, 2 acknowledged, 3 error
  logic [1:0] m_ps = 2'b00;
  bit         m_by_st = 1'b0;
  bit         m_to = 1'b0;
  logic [1:0] h_ds [0:7];
  logic       h_st [0:7];
  logic       h_be [0:7];
  logic [1:0] size_tab [0:3];

  initial begin
    size_tab[0] = 2'b11;  // LL long
    size_tab[1] = 2'b10;  // LH word
    size_tab[2] = 2'b01;  // HL byte
    size_tab[3] = 2'b00;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = 0; m_ps = 2'b00; m_by_st = 1'b0; m_to = 1'b0;
      for (int k = 0; k < 8; k++) begin
        h_ds[k] = 2'b11; h_st[k] = 1'b1; h_be[k] = 1'b1;
      end
    end else begin
      m_edge++;
      for (int k = 7; k > 0; k--) begin
        h_ds[k] = h_ds[k-1]; h_st[k] = h_st[k-1]; h_be[k] = h_be[k-1];
      end
      h_ds[0] = {ds1, ds0}; h_st[0] = st; h_be[0] = be;
      if (ce) begin
        m_st = 0;
      end else if (m_st == 0) begin
        if (cs) begin
          m_st = 1; m_enter = m_edge; m_to = 1'b0;
        end
      end else if (m_st == 1) begin
        if (h_be[S+1] == 1'b0) begin
          m_st = 3;
        end else if (h_st[1] == 1'b0) begin
          m_st = 2; m_by_st = 1'b1; m_ps = 2'b11;
        end else if (h_ds[S] != 2'b11 && h_ds[S] == h_ds[S+1]) begin
          m_st = 2; m_by_st = 1'b0; m_ps = size_tab[h_ds[S]];
        end else if (m_edge - m_enter == T) begin
          m_st = 3; m_to = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("model_dsack",   dsack,   (m_st == 2 && !m_by_st) ? 8'd1 : 8'd0);
    chk("model_sterm_n", sterm_n, (m_st == 2 && m_by_st)  ? 8'd0 : 8'd1);
    chk("model_ps",      ps,      (m_st == 2) ? {6'd0, m_ps} : 8'd0);
    chk("model_berr_n",  berr_n,  (m_st == 3) ? 8'd0 : 8'd1);
    chk("model_timeout", tmo,     m_to ? 8'd1 : 8'd0);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_cycle();
    cs = 1'b1; cyc(1); cs = 1'b0;
  endtask

  task automatic end_cycle(input string nm);
    ce = 1'b1; cyc(1); ce = 1'b0;
    ds0 = 1'b1; ds1 = 1'b1; st = 1'b1; be = 1'b1;
    chk({nm, "_end_dsack"}, dsack, 0);
    chk({nm, "_end_sterm"}, sterm_n, 1);
    chk({nm, "_end_ps"}, ps, 0);
    chk({nm, "_end_berr"}, berr_n, 1);
    cyc(4);
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_dsack"}, dsack, 0);
    chk({nm, "_sterm"}, sterm_n, 1);
    chk({nm, "_ps"}, ps, 0);
    chk({nm, "_berr"}, berr_n, 1);
  endtask

  initial begin
    cs = 0; ce = 0; ds0 = 1; ds1 = 1; st = 1; be = 1;
    #1 rst_n = 1'b0;
    #2 chk_idle_outputs("reset");
    chk("reset_timeout", tmo, 0);
    cyc(2); rst_n = 1'b1; cyc(2);

    // Long ack: pair low from clock 3, DSACK at clock 6.
    start_cycle(); cyc(2);
    ds0 = 0; ds1 = 0;
    cyc(3); chk("long_pre_dsack", dsack, 0);
    cyc(1); chk("long_dsack", dsack, 1); chk("long_ps", ps, 2'b11);
    end_cycle("long");

    // Skew: DSACK0_ at clock 3, DSACK1_ at clock 4; no byte acceptance.
    start_cycle(); cyc(2);
    ds0 = 0; cyc(1); ds1 = 0;
    cyc(3); chk("skew_pre_dsack", dsack, 0); chk("skew_pre_ps", ps, 0);
    cyc(1); chk("skew_dsack", dsack, 1); chk("skew_ps", ps, 2'b11);
    end_cycle("skew");

    // Byte and word ports.
    start_cycle(); ds0 = 0;
    cyc(3); chk("byte_pre_dsack", dsack, 0);
    cyc(1); chk("byte_dsack", dsack, 1); chk("byte_ps", ps, 2'b01);
    end_cycle("byte");
    start_cycle(); ds1 = 0;
    cyc(4); chk("word_dsack", dsack, 1); chk("word_ps", ps, 2'b10);
    end_cycle("word");

    // STERM wins over a DSACK pair sampled on the same edge.
    start_cycle(); cyc(1);
    st = 0; ds0 = 0; ds1 = 0;
    cyc(1); st = 1; chk("sterm_pre", sterm_n, 1);
    cyc(1); chk("sterm_low", sterm_n, 0); chk("sterm_dsack", dsack, 0); chk("sterm_ps", ps, 2'b11);
    cyc(4); chk("sterm_hold", sterm_n, 0); chk("sterm_hold_dsack", dsack, 0);
    end_cycle("sterm");

    // External bus error, held after the raw input releases.
    start_cycle(); be = 0;
    cyc(3); chk("berr_pre", berr_n, 1);
    cyc(1); chk("berr_low", berr_n, 0); chk("berr_no_timeout", tmo, 0);
    be = 1; cyc(3); chk("berr_hold", berr_n, 0);
    end_cycle("berr");

    // Timeout after T clocks in WAIT; sticky flag cleared by the next start.
    start_cycle(); chk("to_start_flag", tmo, 0);
    cyc(7); chk("to_pre_berr", berr_n, 1); chk("to_pre_flag", tmo, 0);
    cyc(1); chk("to_berr", berr_n, 0); chk("to_flag", tmo, 1);
    end_cycle("to");
    chk("to_sticky", tmo, 1);
    start_cycle(); chk("to_cleared", tmo, 0);
    cyc(8); chk("to2_berr", berr_n, 0); chk("to2_flag", tmo, 1);

    // Async reset while in ERR with TIMEOUT set.
    #3 rst_n = 1'b0;
    #1 chk_idle_outputs("rst_err"); chk("rst_err_timeout", tmo, 0);
    cyc(1); rst_n = 1'b1; cyc(2);

    // Async reset mid-WAIT with a DSACK pair in the synchroniser.
    start_cycle(); cyc(2);
    ds0 = 0; ds1 = 0; cyc(2);
    #3 rst_n = 1'b0;
    #1 chk_idle_outputs("rst_wait"); chk("rst_wait_timeout", tmo, 0);
    ds0 = 1; ds1 = 1;
    cyc(1); rst_n = 1'b1; cyc(2);
    start_cycle();
    cyc(7); chk("rst_wait_no_ack", dsack, 0); chk("rst_wait_pre_to", berr_n, 1);
    cyc(1); chk("rst_wait_to", berr_n, 0);
    end_cycle("rst_wait");

    // CYCLE_END and CYCLE_START together in ACK: back to IDLE, start ignored.
    start_cycle(); ds0 = 0; ds1 = 0;
    cyc(4); chk("col_ack", dsack, 1);
    ce = 1; cs = 1; cyc(1); ce = 0; cs = 0;
    chk("col_idle", dsack, 0);
    cyc(10); chk("col_no_wait_dsack", dsack, 0); chk("col_no_wait_berr", berr_n, 1);
    ds0 = 1; ds1 = 1; cyc(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
